// File: rtl/ct_mmu_dutlb_huge_refill.sv
// Huge-page uTLB refill engine: takes a lookup miss, fetches the mapping from
// the JTLB and writes it into one of four huge entries, honouring flushes.
module ct_mmu_dutlb_huge_refill (
    input  logic        utlb_entry_clk,
    input  logic        cpurst_b,
    input  logic        utlb_miss_vld,
    input  logic [26:0] utlb_miss_vpn,
    input  logic [15:0] utlb_miss_asid,
    output logic        utlb_refill_busy,
    output logic        mmu_jtlb_req,
    output logic [26:0] mmu_jtlb_req_vpn,
    output logic [15:0] mmu_jtlb_req_asid,
    input  logic        jtlb_mmu_grant,
    input  logic        jtlb_mmu_resp_vld,
    input  logic        jtlb_mmu_resp_fault,
    input  logic        jtlb_mmu_resp_huge,
    input  logic [27:0] jtlb_mmu_resp_ppn,
    input  logic [13:0] jtlb_mmu_resp_flg,
    input  logic        jtlb_mmu_resp_g,
    input  logic [3:0]  utlb_entry_vld,
    input  logic        regs_utlb_clr,
    input  logic        tlboper_utlb_clr,
    output logic [3:0]  utlb_entry_upd,
    output logic [26:0] utlb_upd_vpn,
    output logic [27:0] utlb_upd_ppn,
    output logic [13:0] utlb_upd_flg,
    output logic [15:0] utlb_upd_asid,
    output logic        utlb_upd_g,
    output logic        utlb_refill_done,
    output logic        utlb_refill_fault
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, UPD} state_t;

    typedef struct packed {
        logic [27:0] ppn;
        logic [13:0] flg;
        logic        g;
    } pte_t;

    state_t      state, state_nxt;
    logic        flush;
    logic        discard, discard_nxt;
    logic        done_q, done_nxt;
    logic        fault_q, fault_nxt;
    logic        miss_take, resp_take;
    logic [1:0]  ptr;
    logic [1:0]  victim;
    logic        upd_fire;
    logic [26:0] vpn_q;
    logic [15:0] asid_q;
    pte_t        pte_q;

    assign flush = regs_utlb_clr | tlboper_utlb_clr;

    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        done_nxt    = 1'b0;
        fault_nxt   = 1'b0;
        miss_take   = 1'b0;
        resp_take   = 1'b0;
        unique case (state)
            IDLE: begin
                discard_nxt = 1'b0;
                if (utlb_miss_vld && !flush) begin
                    miss_take = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (jtlb_mmu_grant) begin
                    state_nxt   = WAIT;
                    discard_nxt = flush;
                end else if (flush) begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (jtlb_mmu_resp_vld) begin
                    state_nxt   = IDLE;
                    discard_nxt = 1'b0;
                    done_nxt    = 1'b1;
                    if (jtlb_mmu_resp_fault) begin
                        fault_nxt = 1'b1;
                    end else if (jtlb_mmu_resp_huge && !discard && !flush) begin
                        // Completion is reported from UPD instead.
                        done_nxt  = 1'b0;
                        resp_take = 1'b1;
                        state_nxt = UPD;
                    end
                end else if (flush) begin
                    discard_nxt = 1'b1;
                end
            end
            UPD: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Lowest free entry wins; fall back to round-robin when all are valid.
    always_comb begin
        victim = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (!utlb_entry_vld[i]) victim = 2'(i);
        end
    end

    assign upd_fire = (state == UPD) && !flush;

    always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state   <= IDLE;
            discard <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            ptr     <= 2'd0;
            vpn_q   <= '0;
            asid_q  <= '0;
            pte_q   <= '0;
        end else begin
            state   <= state_nxt;
            discard <= discard_nxt;
            done_q  <= done_nxt;
            fault_q <= fault_nxt;
            if (miss_take) begin
                vpn_q  <= utlb_miss_vpn;
                asid_q <= utlb_miss_asid;
            end
            if (resp_take) begin
                pte_q <= '{ppn: jtlb_mmu_resp_ppn, flg: jtlb_mmu_resp_flg, g: jtlb_mmu_resp_g};
            end
            if (upd_fire && (&utlb_entry_vld)) begin
                ptr <= ptr + 2'd1;
            end
        end
    end

    assign utlb_refill_busy  = (state != IDLE);
    assign mmu_jtlb_req      = (state == REQ);
    assign mmu_jtlb_req_vpn  = vpn_q;
    assign mmu_jtlb_req_asid = asid_q;
    assign utlb_entry_upd    = upd_fire ? (4'b0001 << victim) : 4'b0000;
    assign utlb_upd_vpn      = vpn_q;
    assign utlb_upd_asid     = asid_q;
    assign utlb_upd_ppn      = pte_q.ppn;
    assign utlb_upd_flg      = pte_q.flg;
    assign utlb_upd_g        = pte_q.g;
    assign utlb_refill_done  = done_q | (state == UPD);
    assign utlb_refill_fault = fault_q;

endmodule

// File: doc/ct_mmu_dutlb_huge_refill.md
CT_MMU_DUTLB_HUGE_REFILL -- requirements
Module: ct_mmu_dutlb_huge_refill

Interface
REQ-001 SHALL have: utlb_entry_clk  in  1  clock; all state on its rising edge.
REQ-002 SHALL have: cpurst_b  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have: utlb_miss_vld  in  1  huge-page lookup miss request, qualified by !utlb_refill_busy.
REQ-004 SHALL have: utlb_miss_vpn  in  27  VPN of the miss; utlb_miss_asid  in  16  ASID of the miss.
REQ-005 SHALL have: utlb_refill_busy  out  1  high whenever state != IDLE.
REQ-006 SHALL have: mmu_jtlb_req  out  1  JTLB request; mmu_jtlb_req_vpn  out  27; mmu_jtlb_req_asid  out  16.
REQ-007 SHALL have: jtlb_mmu_grant  in  1  request accepted.
REQ-008 SHALL have: jtlb_mmu_resp_vld  in  1; jtlb_mmu_resp_fault  in  1; jtlb_mmu_resp_huge  in  1 (mapping is a huge page).
REQ-009 SHALL have: jtlb_mmu_resp_ppn  in  28; jtlb_mmu_resp_flg  in  14; jtlb_mmu_resp_g  in  1.
REQ-010 SHALL have: utlb_entry_vld  in  4  valid bits of the 4 huge entries.
REQ-011 SHALL have: regs_utlb_clr  in  1; tlboper_utlb_clr  in  1  flush requests (flush = OR of both).
REQ-012 SHALL have: utlb_entry_upd  out  4  one-hot entry write strobe.
REQ-013 SHALL have: utlb_upd_vpn  out  27; utlb_upd_ppn  out  28; utlb_upd_flg  out  14; utlb_upd_asid  out  16; utlb_upd_g  out  1.
REQ-014 SHALL have: utlb_refill_done  out  1  one-cycle completion pulse; utlb_refill_fault  out  1  one-cycle fault pulse.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, WAIT, UPD.
REQ-021 IDLE: utlb_miss_vld && !flush -> latch vpn/asid, go REQ next cycle; miss with flush same cycle is ignored.
REQ-022 REQ: mmu_jtlb_req=1 with latched vpn/asid held stable until grant; grant -> WAIT; flush (no grant) -> IDLE, no done pulse.
REQ-023 REQ with grant and flush same cycle -> WAIT with discard flag set.
REQ-024 WAIT: flush sets discard flag (sticky until IDLE); state waits for jtlb_mmu_resp_vld regardless of discard.
REQ-025 WAIT resp_vld: fault=1 -> IDLE, refill_fault and refill_done pulse next cycle, no update.
REQ-026 WAIT resp_vld: fault=0, huge=0 or discard=1 -> IDLE, done pulse, no update.
REQ-027 WAIT resp_vld: fault=0, huge=1, discard=0 -> capture ppn/flg/g, go UPD.
REQ-028 UPD: exactly one bit of utlb_entry_upd high for one cycle, all utlb_upd_* fields stable that cycle; done pulse same cycle; -> IDLE.
REQ-029 UPD with flush same cycle: utlb_entry_upd=0, done pulse, -> IDLE (flush wins).
REQ-030 Victim: lowest-index entry with utlb_entry_vld=0, sampled in UPD cycle; if all valid, entry at 2-bit round-robin pointer.
REQ-031 Pointer increments (wraps 3->0) only on an UPD that replaced a valid entry.
REQ-032 Minimum latency miss-accept to upd strobe: 3 cycles (grant and resp in consecutive cycles).
REQ-033 resp_vld outside WAIT and grant outside REQ SHALL be ignored.
REQ-034 utlb_refill_done and utlb_refill_fault SHALL never be high in consecutive cycles for one miss.

Reset
REQ-040 On cpurst_b low: state IDLE, discard 0, pointer 0, all latched fields 0, all outputs 0 (busy 0, req 0, upd 0, done 0, fault 0).
REQ-041 Reset mid-refill SHALL abandon the refill with no upd strobe after release.

Verification
REQ-050 Miss vpn=0x1234567, asid=0x0005, all entries invalid; grant c+1, resp huge ppn=0xABCDEF0 c+2 -> upd=0001 at c+3, fields match, done pulse.
REQ-051 All 4 valid, four back-to-back refills -> upd 0001,0010,0100,1000, then 0001 on the fifth.
REQ-052 Flush during WAIT, later resp huge -> no upd strobe, done pulse, busy drops.
REQ-053 Resp fault=1 -> fault and done pulse one cycle, upd=0000.
REQ-054 Flush in UPD cycle -> upd=0000, pointer unchanged.
REQ-055 Reset asserted in WAIT, resp after release -> ignored, all outputs 0.
